// File: rtl/rvcpu_axi_pkg.sv
// Shared AXI4-Lite constants, bridge state encoding and the address window check
// used by the simulation-memory bridge.
package rvcpu_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_WAIT,
    ST_WR_RESP
  } bridge_state_e;

  // Subtracting first keeps the upper bound correct even when base+size wraps past 2^32.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/axi4lite_mem_bridge.sv
// AXI4-Lite slave turning one transaction at a time into a single-cycle read or
// write strobe on the simulation memory port, with range check and wait states.
module axi4lite_mem_bridge
  import rvcpu_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0800_0000,
  parameter int unsigned LATENCY   = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [AXI_ADDR_W-1:0]   araddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [AXI_DATA_W-1:0]   rdata,
  output logic [1:0]              rresp,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [AXI_ADDR_W-1:0]   awaddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [AXI_DATA_W-1:0]   wdata,
  input  logic [3:0]              wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  output logic                    mem_ren,
  output logic [AXI_ADDR_W-1:0]   mem_raddr,
  input  logic [AXI_DATA_W-1:0]   mem_rdata,
  output logic                    mem_wen,
  output logic [AXI_ADDR_W-1:0]   mem_waddr,
  output logic [AXI_DATA_W-1:0]   mem_wdata,
  output logic [3:0]              mem_wmask
);

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  bridge_state_e          state_reg, state_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic                   prio_reg, prio_next;
  logic [AXI_ADDR_W-1:0]  raddr_reg, raddr_next;
  logic [AXI_ADDR_W-1:0]  waddr_reg, waddr_next;
  logic [AXI_DATA_W-1:0]  wdata_reg, wdata_next;
  logic [3:0]             wmask_reg, wmask_next;
  logic [AXI_DATA_W-1:0]  rdata_reg, rdata_next;
  logic [1:0]             rresp_reg, rresp_next;
  logic [1:0]             bresp_reg, bresp_next;
  logic                   rd_in_range;
  logic                   wr_in_range;
  logic                   wr_pair;

  assign rd_in_range = addr_in_range(raddr_reg, ADDR_BASE, ADDR_SIZE);
  assign wr_in_range = addr_in_range(waddr_reg, ADDR_BASE, ADDR_SIZE);
  assign wr_pair     = awvalid && wvalid;

  assign rdata     = rdata_reg;
  assign rresp     = rresp_reg;
  assign bresp     = bresp_reg;
  assign mem_raddr = raddr_reg;
  assign mem_waddr = waddr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wmask = wmask_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      prio_reg  <= 1'b0;
      raddr_reg <= '0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      wmask_reg <= 4'd0;
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
      bresp_reg <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      prio_reg  <= prio_next;
      raddr_reg <= raddr_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      wmask_reg <= wmask_next;
      rdata_reg <= rdata_next;
      rresp_reg <= rresp_next;
      bresp_reg <= bresp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    prio_next  = prio_reg;
    raddr_next = raddr_reg;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    wmask_next = wmask_reg;
    rdata_next = rdata_reg;
    rresp_next = rresp_reg;
    bresp_next = bresp_reg;
    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    rvalid     = 1'b0;
    bvalid     = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Grant conditions are mutually exclusive; prio only breaks a tie.
        if (arvalid && (!wr_pair || !prio_reg)) begin
          arready    = 1'b1;
          raddr_next = araddr;
          cnt_next   = LAT4;
          prio_next  = 1'b1;
          state_next = ST_RD_WAIT;
        end else if (wr_pair && (!arvalid || prio_reg)) begin
          awready    = 1'b1;
          wready     = 1'b1;
          waddr_next = awaddr;
          wdata_next = wdata;
          wmask_next = wstrb;
          cnt_next   = LAT4;
          prio_next  = 1'b0;
          state_next = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          if (rd_in_range) begin
            mem_ren    = 1'b1;
            rdata_next = mem_rdata;
            rresp_next = RESP_OKAY;
          end else begin
            rdata_next = '0;
            rresp_next = RESP_SLVERR;
          end
          state_next = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        rvalid = 1'b1;
        if (rready) state_next = ST_IDLE;
      end
      ST_WR_WAIT: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          if (wr_in_range) begin
            mem_wen    = 1'b1;
            bresp_next = RESP_OKAY;
          end else begin
            bresp_next = RESP_SLVERR;
          end
          state_next = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Nothing leaves the bridge while reset is asserted, whatever state it was in.
    if (!reset) begin
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      rvalid  = 1'b0;
      bvalid  = 1'b0;
      mem_ren = 1'b0;
      mem_wen = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_mem_bridge.sv
// Directed bench for the AXI4-Lite memory bridge: three instances with LATENCY 0, 3
// and 5 share clock and reset; a negedge monitor logs handshakes and strobes.
module tb_axi4lite_mem_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        arvalid[3], arready[3], rvalid[3], rready[3];
  logic        awvalid[3], awready[3], wvalid[3], wready[3], bvalid[3], bready[3];
  logic        mem_ren[3], mem_wen[3];
  logic [31:0] araddr[3], awaddr[3], wdata[3], rdata[3], mem_raddr[3], mem_rdata[3];
  logic [31:0] mem_waddr[3], mem_wdata[3];
  logic [3:0]  wstrb[3], mem_wmask[3];
  logic [1:0]  rresp[3], bresp[3];

  always #5 clock = ~clock;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int unsigned LAT = (gi == 0) ? 0 : ((gi == 1) ? 3 : 5);
      axi4lite_mem_bridge #(.LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid[gi]), .arready(arready[gi]), .araddr(araddr[gi]),
        .rvalid(rvalid[gi]), .rready(rready[gi]), .rdata(rdata[gi]), .rresp(rresp[gi]),
        .awvalid(awvalid[gi]), .awready(awready[gi]), .awaddr(awaddr[gi]),
        .wvalid(wvalid[gi]), .wready(wready[gi]), .wdata(wdata[gi]), .wstrb(wstrb[gi]),
        .bvalid(bvalid[gi]), .bready(bready[gi]), .bresp(bresp[gi]),
        .mem_ren(mem_ren[gi]), .mem_raddr(mem_raddr[gi]), .mem_rdata(mem_rdata[gi]),
        .mem_wen(mem_wen[gi]), .mem_waddr(mem_waddr[gi]), .mem_wdata(mem_wdata[gi]),
        .mem_wmask(mem_wmask[gi])
      );
    end
  endgenerate

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  int ar_n[3] = '{default: 0}, aw_n[3] = '{default: 0}, r_n[3] = '{default: 0};
  int b_n[3] = '{default: 0}, ren_n[3] = '{default: 0}, wen_n[3] = '{default: 0};
  int both_n[3] = '{default: 0}, rst_act[3] = '{default: 0}, rv_hi[3] = '{default: 0};
  int bv_hi[3] = '{default: 0}, wrdy_hi[3] = '{default: 0}, hold_err[3] = '{default: 0};
  int ar_c[3] = '{default: 0}, aw_c[3] = '{default: 0}, ren_c[3] = '{default: 0};
  int wen_c[3] = '{default: 0}, rv_c[3] = '{default: 0}, bv_c[3] = '{default: 0};
  logic [31:0] ren_a[3], wen_a[3], wen_d[3], rd_cap[3], rd_p[3];
  logic [3:0]  wen_m[3];
  logic [1:0]  rr_cap[3], br_cap[3], rr_p[3], br_p[3];
  logic        rv_p[3] = '{default: 1'b0}, bv_p[3] = '{default: 1'b0};
  logic        rhs_p[3] = '{default: 1'b0}, bhs_p[3] = '{default: 1'b0};
  int          gr_log[64];
  int          gr_n = 0;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset && (arready[i] | awready[i] | wready[i] | rvalid[i] | bvalid[i] |
                     mem_ren[i] | mem_wen[i]))
        rst_act[i]++;
      if (arvalid[i] && arready[i]) begin
        ar_n[i]++; ar_c[i] = cyc;
        if (i == 0 && gr_n < 64) begin gr_log[gr_n] = 0; gr_n++; end
      end
      if (awvalid[i] && awready[i] && wvalid[i] && wready[i]) begin
        aw_n[i]++; aw_c[i] = cyc;
        if (i == 0 && gr_n < 64) begin gr_log[gr_n] = 1; gr_n++; end
      end
      if (awready[i] || wready[i]) wrdy_hi[i]++;
      if (mem_ren[i]) begin ren_n[i]++; ren_c[i] = cyc; ren_a[i] = mem_raddr[i]; end
      if (mem_wen[i]) begin
        wen_n[i]++; wen_c[i] = cyc; wen_a[i] = mem_waddr[i];
        wen_d[i] = mem_wdata[i]; wen_m[i] = mem_wmask[i];
      end
      if (mem_ren[i] && mem_wen[i]) both_n[i]++;
      if (rvalid[i]) rv_hi[i]++;
      if (bvalid[i]) bv_hi[i]++;
      if (rvalid[i] && !rv_p[i]) begin rv_c[i] = cyc; rd_cap[i] = rdata[i]; rr_cap[i] = rresp[i]; end
      if (bvalid[i] && !bv_p[i]) begin bv_c[i] = cyc; br_cap[i] = bresp[i]; end
      // A response that was offered but not taken must still be there, unchanged.
      if (reset && rv_p[i] && !rhs_p[i] && (!rvalid[i] || rdata[i] != rd_p[i] || rresp[i] != rr_p[i]))
        hold_err[i]++;
      if (reset && bv_p[i] && !bhs_p[i] && (!bvalid[i] || bresp[i] != br_p[i]))
        hold_err[i]++;
      if (rvalid[i] && rready[i]) r_n[i]++;
      if (bvalid[i] && bready[i]) b_n[i]++;
      rv_p[i] = rvalid[i]; bv_p[i] = bvalid[i];
      rhs_p[i] = rvalid[i] && rready[i]; bhs_p[i] = bvalid[i] && bready[i];
      rd_p[i] = rdata[i]; rr_p[i] = rresp[i]; br_p[i] = bresp[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input int i, input logic [31:0] a, input int hold);
    int n0, n1, h0, b;
    n0 = ar_n[i]; n1 = r_n[i]; h0 = rv_hi[i];
    arvalid[i] = 1'b1; araddr[i] = a; rready[i] = (hold == 0);
    b = 0;
    while (ar_n[i] == n0 && b < 60) begin tick(); b++; end
    check("rd_ar_handshake", 32'(ar_n[i] - n0), 32'd1);
    arvalid[i] = 1'b0;
    b = 0;
    while (r_n[i] == n1 && b < 60) begin
      if (rv_hi[i] - h0 >= hold) rready[i] = 1'b1;
      tick(); b++;
    end
    check("rd_r_handshake", 32'(r_n[i] - n1), 32'd1);
    rready[i] = 1'b1;
    $display("rd inst=%0d addr=%h data=%h resp=%0d", i, a, rd_cap[i], rr_cap[i]);
  endtask

  task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] m, input int hold);
    int n0, n1, h0, b;
    n0 = aw_n[i]; n1 = b_n[i]; h0 = bv_hi[i];
    awvalid[i] = 1'b1; wvalid[i] = 1'b1; awaddr[i] = a; wdata[i] = d; wstrb[i] = m;
    bready[i] = (hold == 0);
    b = 0;
    while (aw_n[i] == n0 && b < 60) begin tick(); b++; end
    check("wr_aw_handshake", 32'(aw_n[i] - n0), 32'd1);
    awvalid[i] = 1'b0; wvalid[i] = 1'b0;
    b = 0;
    while (b_n[i] == n1 && b < 60) begin
      if (bv_hi[i] - h0 >= hold) bready[i] = 1'b1;
      tick(); b++;
    end
    check("wr_b_handshake", 32'(b_n[i] - n1), 32'd1);
    bready[i] = 1'b1;
    $display("wr inst=%0d addr=%h data=%h strb=%b resp=%0d", i, a, d, m, br_cap[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w, h, b, g0, rel, rvh;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      arvalid[i] = 1'b1; awvalid[i] = 1'b1; wvalid[i] = 1'b1; rready[i] = 1'b1; bready[i] = 1'b1;
      araddr[i] = 32'h8000_0000; awaddr[i] = 32'h8000_0000; wdata[i] = '0; wstrb[i] = 4'hF;
      mem_rdata[i] = 32'h1111_1111;
    end

    // Reset: everything held low with requests pending, registered responses cleared.
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("reset_rdata", rdata[i], 32'h0);
      check("reset_rresp", 32'(rresp[i]), 32'h0);
      check("reset_bresp", 32'(bresp[i]), 32'h0);
      arvalid[i] = 1'b0; awvalid[i] = 1'b0; wvalid[i] = 1'b0;
    end
    reset = 1'b1;
    tick();

    // Read and write contending every cycle: grants alternate starting with read.
    g0 = gr_n;
    arvalid[0] = 1'b1; araddr[0] = 32'h8000_0100;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; awaddr[0] = 32'h8000_0104; wdata[0] = 32'hA5A5_0001;
    b = 0;
    while (gr_n - g0 < 4 && b < 200) begin tick(); b++; end
    arvalid[0] = 1'b0; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    repeat (8) tick();
    check("arb_grants", 32'(gr_n - g0), 32'd4);
    for (int k = 0; k < 4; k++) check("arb_order", 32'(gr_log[g0 + k]), 32'(k % 2));
    $display("arb inst=0 grants=%0d %0d %0d %0d", gr_log[g0], gr_log[g0+1], gr_log[g0+2], gr_log[g0+3]);

    // LATENCY=0 read.
    mem_rdata[0] = 32'hDEAD_BEEF;
    n = ren_n[0];
    rd(0, 32'h8000_0000, 0);
    check("l0_ren_count", 32'(ren_n[0] - n), 32'd1);
    check("l0_ren_cycle", 32'(ren_c[0] - ar_c[0]), 32'd1);
    check("l0_rvalid_cycle", 32'(rv_c[0] - ar_c[0]), 32'd2);
    check("l0_raddr", ren_a[0], 32'h8000_0000);
    check("l0_rdata", rd_cap[0], 32'hDEAD_BEEF);
    check("l0_rresp", 32'(rr_cap[0]), 32'h0);

    // LATENCY=3 write with byte strobes and a stalled B channel.
    w = wen_n[1];
    wr(1, 32'h8000_0010, 32'h1234_5678, 4'b0110, 3);
    check("l3_wen_count", 32'(wen_n[1] - w), 32'd1);
    check("l3_wen_cycle", 32'(wen_c[1] - aw_c[1]), 32'd4);
    check("l3_bvalid_cycle", 32'(bv_c[1] - aw_c[1]), 32'd5);
    check("l3_waddr", wen_a[1], 32'h8000_0010);
    check("l3_wdata", wen_d[1], 32'h1234_5678);
    check("l3_wmask", 32'(wen_m[1]), 32'h6);
    check("l3_bresp", 32'(br_cap[1]), 32'h0);

    // Window edges: below base, last word, wrap-around, one past the end.
    n = ren_n[0]; w = wen_n[0];
    rd(0, 32'h7FFF_FFFC, 2);
    check("oor_low_ren", 32'(ren_n[0] - n), 32'd0);
    check("oor_low_rresp", 32'(rr_cap[0]), 32'h2);
    check("oor_low_rdata", rd_cap[0], 32'h0);
    mem_rdata[0] = 32'hCAFE_F00D;
    rd(0, 32'h87FF_FFFC, 0);
    check("top_word_ren", 32'(ren_n[0] - n), 32'd1);
    check("top_word_rdata", rd_cap[0], 32'hCAFE_F00D);
    check("top_word_rresp", 32'(rr_cap[0]), 32'h0);
    rd(0, 32'hFFFF_FFFC, 0);
    check("wrap_ren", 32'(ren_n[0] - n), 32'd1);
    check("wrap_rresp", 32'(rr_cap[0]), 32'h2);
    wr(0, 32'h8800_0000, 32'h0BAD_0BAD, 4'hF, 0);
    check("oor_high_wen", 32'(wen_n[0] - w), 32'd0);
    check("oor_high_bresp", 32'(br_cap[0]), 32'h2);

    // A lone AW or lone W must never be accepted.
    w = wen_n[1]; n = aw_n[1]; h = wrdy_hi[1];
    awvalid[1] = 1'b1; awaddr[1] = 32'h8000_0040; wvalid[1] = 1'b0;
    repeat (5) tick();
    awvalid[1] = 1'b0; wvalid[1] = 1'b1;
    repeat (3) tick();
    wvalid[1] = 1'b0;
    check("lone_accept", 32'(aw_n[1] - n), 32'd0);
    check("lone_ready", 32'(wrdy_hi[1] - h), 32'd0);
    wr(1, 32'h8000_0040, 32'h0000_00FF, 4'b0001, 0);
    check("lone_then_pair_wen", 32'(wen_n[1] - w), 32'd1);

    // Reset in the middle of a LATENCY=5 read wait.
    n = ren_n[2]; rvh = rv_hi[2]; g0 = ar_n[2];
    arvalid[2] = 1'b1; araddr[2] = 32'h8000_0020;
    b = 0;
    while (ar_n[2] == g0 && b < 20) begin tick(); b++; end
    arvalid[2] = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    arvalid[2] = 1'b1; awvalid[2] = 1'b1; wvalid[2] = 1'b1;
    awaddr[2] = 32'h8000_0024; wdata[2] = 32'h7777_0000; wstrb[2] = 4'hF;
    repeat (2) tick();
    check("rst_mid_no_ren", 32'(ren_n[2] - n), 32'd0);
    check("rst_mid_no_rvalid", 32'(rv_hi[2] - rvh), 32'd0);
    g0 = ar_n[2]; w = aw_n[2];
    reset = 1'b1;
    rel = cyc;
    b = 0;
    while (ar_n[2] == g0 && b < 20) begin tick(); b++; end
    arvalid[2] = 1'b0;
    check("rst_read_first", 32'(ar_c[2] - rel), 32'd0);
    check("rst_write_waits", 32'(aw_n[2] - w), 32'd0);
    b = 0;
    while (aw_n[2] == w && b < 40) begin tick(); b++; end
    awvalid[2] = 1'b0; wvalid[2] = 1'b0;
    repeat (10) tick();
    check("l5_ren_cycle", 32'(ren_c[2] - ar_c[2]), 32'd6);
    check("l5_rvalid_cycle", 32'(rv_c[2] - ar_c[2]), 32'd7);
    check("l5_wen_cycle", 32'(wen_c[2] - aw_c[2]), 32'd6);
    $display("rst inst=2 read_at=%0d release_at=%0d", ar_c[2], rel);

    for (int i = 0; i < 3; i++) begin
      check("no_activity_in_reset", 32'(rst_act[i]), 32'd0);
      check("ren_wen_exclusive", 32'(both_n[i]), 32'd0);
      check("resp_held", 32'(hold_err[i]), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
